// File: rtl/sec_input_pkg.sv
// Shared constants and channel naming for the security-panel input conditioner.
package sec_input_pkg;
  localparam int N_CH_DEF = 4;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_idx_t;
endpackage

// File: rtl/debounce_channel.sv
// One button line: synchronizer, stability counter, registered clean level and edge strobes.
module debounce_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Any sample matching the accepted level restarts the stability window.
    if (s != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        clean_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
endmodule

// File: rtl/input_debouncer.sv
// Debounces the raw panel buttons into clean, clock-aligned levels and edge strobes.
module input_debouncer
  import sec_input_pkg::*;
#(
  parameter int N_CH            = N_CH_DEF,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            all_idle
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_in    (raw_in[i]),
      .clean_out (clean_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  assign all_idle = ~|clean_out;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed checks of the debouncer: reset, latency, glitch rejection, multi-channel, async reset.
module tb_input_debouncer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw_in = 4'h0;
  logic [3:0] clean_out, rise_pulse, fall_pulse;
  logic       all_idle;
  int errors = 0;
  int checks = 0;

  input_debouncer #(.N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .all_idle  (all_idle)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    raw_in = 4'h0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    raw_in = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if (clean_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || all_idle !== 1'b1) begin
        errors++;
        $display("FAIL reset cyc%0d: clean=%h rise=%h fall=%h idle=%b, want 0 0 0 1",
                 i, clean_out, rise_pulse, fall_pulse, all_idle);
      end
    end
    raw_in = 4'h0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    do_reset();
    raw_in = 4'h1;
    step(17);
    checks++;
    if (clean_out !== 4'h0 || rise_pulse !== 4'h0 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge17: clean=%h rise=%h idle=%b, want 0 0 1", clean_out, rise_pulse, all_idle);
    end
    step(1);
    checks++;
    if (clean_out !== 4'h1 || rise_pulse !== 4'h1 || fall_pulse !== 4'h0 || all_idle !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge18: clean=%h rise=%h fall=%h idle=%b, want 1 1 0 0",
               clean_out, rise_pulse, fall_pulse, all_idle);
    end
    step(1);
    checks++;
    if (clean_out !== 4'h1 || rise_pulse !== 4'h0) begin
      errors++;
      $display("FAIL latency_strobe_width: clean=%h rise=%h, want 1 0", clean_out, rise_pulse);
    end
  endtask

  task automatic test_short_pulse();
    do_reset();
    raw_in = 4'h2;
    step(10);
    raw_in = 4'h0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      checks++;
      if (clean_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
        errors++;
        $display("FAIL short_pulse cyc%0d: clean=%h rise=%h fall=%h, want 0 0 0",
                 i, clean_out, rise_pulse, fall_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    int n_rise = 0;
    int at     = -1;
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      raw_in = (seg % 2 == 0) ? 4'h4 : 4'h0;
      for (int k = 0; k < 3; k++) begin
        step(1);
        if (rise_pulse !== 4'h0 || clean_out !== 4'h0) n_rise++;
      end
    end
    raw_in = 4'h4;
    for (int i = 1; i <= 25; i++) begin
      step(1);
      if (rise_pulse !== 4'h0) begin
        n_rise++;
        at = i;
      end
    end
    checks++;
    if (n_rise !== 1 || at !== 18) begin
      errors++;
      $display("FAIL bounce: strobes=%0d at edge %0d, want 1 at edge 18", n_rise, at);
    end
    checks++;
    if (clean_out !== 4'h4) begin
      errors++;
      $display("FAIL bounce_level: clean=%h, want 4", clean_out);
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    raw_in = 4'hF;
    step(17);
    checks++;
    if (clean_out !== 4'h0) begin
      errors++;
      $display("FAIL all_rise_early: clean=%h, want 0", clean_out);
    end
    step(1);
    checks++;
    if (clean_out !== 4'hF || rise_pulse !== 4'hF || fall_pulse !== 4'h0 || all_idle !== 1'b0) begin
      errors++;
      $display("FAIL all_rise: clean=%h rise=%h fall=%h idle=%b, want F F 0 0",
               clean_out, rise_pulse, fall_pulse, all_idle);
    end
    step(1);
    checks++;
    if (rise_pulse !== 4'h0) begin
      errors++;
      $display("FAIL all_rise_width: rise=%h, want 0", rise_pulse);
    end
    raw_in = 4'h0;
    step(17);
    checks++;
    if (clean_out !== 4'hF || fall_pulse !== 4'h0) begin
      errors++;
      $display("FAIL all_fall_early: clean=%h fall=%h, want F 0", clean_out, fall_pulse);
    end
    step(1);
    checks++;
    if (clean_out !== 4'h0 || fall_pulse !== 4'hF || rise_pulse !== 4'h0 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL all_fall: clean=%h fall=%h rise=%h idle=%b, want 0 F 0 1",
               clean_out, fall_pulse, rise_pulse, all_idle);
    end
    step(1);
    checks++;
    if (fall_pulse !== 4'h0) begin
      errors++;
      $display("FAIL all_fall_width: fall=%h, want 0", fall_pulse);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    raw_in = 4'h1;
    step(20);
    raw_in = 4'h9;
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (clean_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0 || all_idle !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: clean=%h rise=%h fall=%h idle=%b, want 0 0 0 1",
               clean_out, rise_pulse, fall_pulse, all_idle);
    end
    #1;
    rst_n = 1'b1;
    step(17);
    checks++;
    if (clean_out !== 4'h0) begin
      errors++;
      $display("FAIL post_reset_early: clean=%h, want 0", clean_out);
    end
    step(1);
    checks++;
    if (clean_out !== 4'h9 || rise_pulse !== 4'h9) begin
      errors++;
      $display("FAIL post_reset_rise: clean=%h rise=%h, want 9 9", clean_out, rise_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_short_pulse();
    test_bounce();
    test_all_channels();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
